// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard/scoreboard unit.
//   fwd_sel_e      : E-stage operand mux select encoding
//   REG_AW_DEFAULT : default register-address width
package hazard_pkg;

    localparam int REG_AW_DEFAULT = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,   // operand from register file
        FWD_W  = 2'b01,   // forward from W-stage result
        FWD_M  = 2'b10    // forward from M-stage ALU result
    } fwd_sel_e;

endpackage

// File: rtl/md_scoreboard.sv
// MDU in-flight tracker: pending-destination vector, latency counter and
// writeback destination register.
//   clk, rst_n : clock, asynchronous active-low reset
//   mdIssue    : MDU op in E issues at this edge
//   issueRd    : destination of the issuing op
//   pend       : one bit per register, set while an MDU write is pending
//   mdBusy     : an MDU op is in flight
//   mdDone     : writeback strobe (final latency cycle)
//   mdRdW      : destination being written back, valid with mdDone
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEFAULT,
    parameter int MDU_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mdIssue,
    input  logic [REG_AW-1:0]      issueRd,
    output logic [2**REG_AW-1:0]   pend,
    output logic                   mdBusy,
    output logic                   mdDone,
    output logic [REG_AW-1:0]      mdRdW
);

    localparam int CNT_W = $clog2(MDU_LAT + 1);
    localparam int DEPTH = 2**REG_AW;

    logic [CNT_W-1:0]  countReg, countNext;
    logic [DEPTH-1:0]  pendReg, pendNext;
    logic [REG_AW-1:0] rdReg, rdNext;

    assign mdBusy = (countReg != '0);
    assign mdDone = (countReg == CNT_W'(1));
    assign pend   = pendReg;
    assign mdRdW  = rdReg;

    always_comb begin
        countNext = countReg;
        rdNext    = rdReg;
        if (mdIssue) begin
            countNext = CNT_W'(MDU_LAT);
            rdNext    = issueRd;
        end else if (mdBusy) begin
            countNext = countReg - CNT_W'(1);
        end
    end

    // Set dominates clear so a back-to-back op to the same register keeps
    // its bit: the retiring op's clear is applied first, then the new set.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
        logic clrBit, setBit;
        assign clrBit = mdDone && (rdReg == REG_AW'(gi));
        assign setBit = mdIssue && (issueRd == REG_AW'(gi)) && (gi != 0);
        assign pendNext[gi] = setBit | (pendReg[gi] & ~clrBit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countReg <= '0;
            pendReg  <= '0;
            rdReg    <= '0;
        end else begin
            countReg <= countNext;
            pendReg  <= pendNext;
            rdReg    <= rdNext;
        end
    end

    // Only one MDU op may be in flight; the stall logic keeps a second op
    // out of E until the first is in its writeback cycle.
    always @(posedge clk) begin
        if (rst_n && mdIssue) begin
            assert (!(mdBusy && !mdDone));
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline with a multi-cycle MDU path.
//   Inputs : D/E/M/W register addresses and write enables, MdOpD/MdOpE,
//            ResultSrcE_MSB (E is a load), PCSrcE (taken branch in E)
//   Outputs: ForwardAE/ForwardBE (E operand select), StallF/StallD,
//            FlushD/FlushE, MdBusy/MdDone/MdRdW (MDU status)
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEFAULT,
    parameter int MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              MdOpD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              MdOpE,
    input  logic              ResultSrcE_MSB,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              MdBusy,
    output logic              MdDone,
    output logic [REG_AW-1:0] MdRdW
);

    logic [2**REG_AW-1:0] pend;
    logic [3:0]           fwdVec;
    logic [1:0]           srcHaz;
    logic [1:0]           matchE;
    logic                 lwStall, mdRawE, wawHaz, sbStall, structStall, stall;

    md_scoreboard #(
        .REG_AW  (REG_AW),
        .MDU_LAT (MDU_LAT)
    ) u_md_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .mdIssue (MdOpE),
        .issueRd (RdE),
        .pend    (pend),
        .mdBusy  (MdBusy),
        .mdDone  (MdDone),
        .mdRdW   (MdRdW)
    );

    // Per-operand forwarding and source-hazard detection.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [REG_AW-1:0] rsE, rsD;
        fwd_sel_e          sel;

        assign rsE = (gi == 0) ? Rs1E : Rs2E;
        assign rsD = (gi == 0) ? Rs1D : Rs2D;

        always_comb begin
            sel = FWD_RF;
            if (rsE != '0 && rsE == RdM && RegWriteM)
                sel = FWD_M;
            else if (rsE != '0 && rsE == RdW && RegWriteW)
                sel = FWD_W;
        end

        assign fwdVec[2*gi +: 2] = sel;
        assign matchE[gi] = (rsD == RdE);
        // A register in its writeback cycle is readable through the
        // register-file write-through, so it no longer blocks D.
        assign srcHaz[gi] = (rsD != '0) && pend[rsD] && !(MdDone && MdRdW == rsD);
    end

    assign ForwardAE = fwdVec[1:0];
    assign ForwardBE = fwdVec[3:2];

    assign lwStall     = ResultSrcE_MSB && (RdE != '0) && (|matchE);
    assign mdRawE      = MdOpE && (RdE != '0) && (|matchE);
    assign wawHaz      = (RegWriteD || MdOpD) && (RdD != '0) && pend[RdD]
                         && !(MdDone && MdRdW == RdD);
    assign sbStall     = (|srcHaz) || wawHaz;
    assign structStall = MdOpD && (MdOpE || (MdBusy && !MdDone));
    assign stall       = lwStall | mdRawE | sbStall | structStall;

    // A taken branch squashes the D instruction, so any stall it raised is
    // moot; the MDU state is older than the branch and keeps running.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            StallF = stall;
            StallD = stall;
            FlushE = stall;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteD, MdOpD, MdOpE, ResultSrcE_MSB, PCSrcE, RegWriteM, RegWriteW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, FlushD, FlushE, MdBusy, MdDone;
    logic [4:0] MdRdW;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] fa, fb;
        logic       st, fd, fe, bsy, dn;
        logic       chkRd;
        logic [4:0] rd;
    } exp_t;

    exp_t expQ[$];

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.REG_AW(5), .MDU_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .MdOpD(MdOpD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .MdOpE(MdOpE),
        .ResultSrcE_MSB(ResultSrcE_MSB), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .MdBusy(MdBusy), .MdDone(MdDone), .MdRdW(MdRdW)
    );

    task automatic cmp(string tag, string field, logic [7:0] obs, logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
        end
    endtask

    task automatic push(string tag, logic [1:0] fa, logic [1:0] fb, logic st, logic fd,
                        logic fe, logic bsy, logic dn, logic chkRd, logic [4:0] rd);
        exp_t e;
        e.tag = tag; e.fa = fa; e.fb = fb; e.st = st; e.fd = fd; e.fe = fe;
        e.bsy = bsy; e.dn = dn; e.chkRd = chkRd; e.rd = rd;
        expQ.push_back(e);
    endtask

    // Let combinational outputs settle, then pop one expectation and compare.
    task automatic settle();
        exp_t e;
        #1;
        checks++;
        assert (expQ.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            cmp(e.tag, "ForwardAE", 8'(ForwardAE), 8'(e.fa));
            cmp(e.tag, "ForwardBE", 8'(ForwardBE), 8'(e.fb));
            cmp(e.tag, "StallF",    8'(StallF),    8'(e.st));
            cmp(e.tag, "StallD",    8'(StallD),    8'(e.st));
            cmp(e.tag, "FlushD",    8'(FlushD),    8'(e.fd));
            cmp(e.tag, "FlushE",    8'(FlushE),    8'(e.fe));
            cmp(e.tag, "MdBusy",    8'(MdBusy),    8'(e.bsy));
            cmp(e.tag, "MdDone",    8'(MdDone),    8'(e.dn));
            if (e.chkRd) cmp(e.tag, "MdRdW", 8'(MdRdW), 8'(e.rd));
            $display("step %-12s FA=%0d FB=%0d St=%0b FD=%0b FE=%0b Busy=%0b Done=%0b RdW=%0d",
                     e.tag, ForwardAE, ForwardBE, StallF, FlushD, FlushE, MdBusy, MdDone, MdRdW);
        end
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0; MdOpD = 0;
        Rs1E = 0; Rs2E = 0; RdE = 0; MdOpE = 0; ResultSrcE_MSB = 0; PCSrcE = 0;
        RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #3;
        push("reset", 0, 0, 0, 0, 0, 0, 0, 1, 0); settle();
        @(negedge clk); rst_n = 1'b1;

        // Forwarding
        @(negedge clk); idle();
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        push("fwd_m_pri", 2, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        @(negedge clk); Rs1E = 0;
        push("fwd_x0", 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        @(negedge clk); idle(); Rs2E = 7; RdW = 7; RegWriteW = 1;
        push("fwd_b_w", 0, 1, 0, 0, 0, 0, 0, 0, 0); settle();
        @(negedge clk); idle(); Rs1E = 5; RdM = 5; RegWriteM = 0; RdW = 5; RegWriteW = 1;
        push("fwd_m_nowe", 1, 0, 0, 0, 0, 0, 0, 0, 0); settle();

        // Load-use
        @(negedge clk); idle(); ResultSrcE_MSB = 1; RdE = 3; Rs2D = 3;
        push("lw_stall", 0, 0, 1, 0, 1, 0, 0, 0, 0); settle();
        @(negedge clk); idle(); Rs2D = 3;
        push("lw_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        @(negedge clk); ResultSrcE_MSB = 1; RdE = 0; Rs2D = 3;
        push("lw_rd0", 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();

        // MDU RAW
        @(negedge clk); idle(); MdOpE = 1; RdE = 9; Rs1D = 9;
        push("raw_t0", 0, 0, 1, 0, 1, 0, 0, 0, 0); settle();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); MdOpE = 0; RdE = 0;
            push($sformatf("raw_t%0d", i), 0, 0, 1, 0, 1, 1, 0, 0, 0); settle();
        end
        @(negedge clk);
        push("raw_t4", 0, 0, 0, 0, 0, 1, 1, 1, 9); settle();
        @(negedge clk);
        push("raw_t5", 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();

        // Structural, then WAW on the second op
        @(negedge clk); idle(); MdOpE = 1; RdE = 4; MdOpD = 1; RdD = 6; RegWriteD = 1;
        push("st_t0", 0, 0, 1, 0, 1, 0, 0, 0, 0); settle();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); MdOpE = 0; RdE = 0;
            push($sformatf("st_t%0d", i), 0, 0, 1, 0, 1, 1, 0, 0, 0); settle();
        end
        @(negedge clk);
        push("st_t4", 0, 0, 0, 0, 0, 1, 1, 1, 4); settle();
        @(negedge clk); MdOpE = 1; RdE = 4; MdOpD = 0; RegWriteD = 1; RdD = 4;
        push("st_t5", 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        for (int i = 6; i <= 8; i++) begin
            @(negedge clk); MdOpE = 0; RdE = 0;
            push($sformatf("waw_t%0d", i), 0, 0, 1, 0, 1, 1, 0, 0, 0); settle();
        end
        @(negedge clk);
        push("waw_t9", 0, 0, 0, 0, 0, 1, 1, 1, 4); settle();

        // Branch priority
        @(negedge clk); idle(); MdOpE = 1; RdE = 9;
        push("br_t0", 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        @(negedge clk); MdOpE = 0; RdE = 0; Rs1D = 9; PCSrcE = 1;
        push("br_t1", 0, 0, 0, 1, 1, 1, 0, 0, 0); settle();
        @(negedge clk); PCSrcE = 0;
        push("br_t2", 0, 0, 1, 0, 1, 1, 0, 0, 0); settle();
        @(negedge clk);
        push("br_t3", 0, 0, 1, 0, 1, 1, 0, 0, 0); settle();
        @(negedge clk);
        push("br_t4", 0, 0, 0, 0, 0, 1, 1, 1, 9); settle();

        // Reset mid-op
        @(negedge clk); idle(); MdOpE = 1; RdE = 12;
        push("rst_t0", 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        @(negedge clk); idle();
        push("rst_t1", 0, 0, 0, 0, 0, 1, 0, 0, 0); settle();
        @(negedge clk); Rs1D = 12;
        push("rst_t2pre", 0, 0, 1, 0, 1, 1, 0, 0, 0); settle();
        rst_n = 1'b0;
        push("rst_async", 0, 0, 0, 0, 0, 0, 0, 1, 0); settle();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            push($sformatf("rst_post%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0); settle();
        end

        cmp("queue", "leftover", 8'(expQ.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Next-generation hazard unit for the 5-stage pipeline. It adds a parametrised multi-cycle multiply/divide unit (MDU) path.
- Keeps the existing functions: E-stage operand forwarding, load-use stall, and branch flush.
- Adds a register scoreboard tracking MDU destinations in flight, plus the busy/latency counter that times MDU writeback.
- Generates the RAW/WAW stalls and structural stalls that the multi-cycle unit requires.

Parameters:
- REG_AW, 5, register address width; scoreboard depth is 2**REG_AW entries.
- MDU_LAT, 4, cycles from MDU issue (in E) to MDU writeback; must be >= 2.
- CNT_W, $clog2(MDU_LAT+1), latency counter width; derived localparam, do not override.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D, Rs2D, RdD  in  REG_AW  D-stage source and destination registers.
- RegWriteD  in  1  D instruction writes a register.
- MdOpD  in  1  D instruction is an MDU op.
- Rs1E, Rs2E, RdE  in  REG_AW  E-stage registers.
- MdOpE  in  1  E instruction is an MDU op; issues this cycle.
- ResultSrcE_MSB  in  1  E instruction is a load.
- PCSrcE  in  1  taken branch/jump resolved in E.
- RdM, RdW  in  REG_AW  M/W destinations.
- RegWriteM, RegWriteW  in  1  M/W write enables. The datapath drives these to 0 for MDU ops.
- ForwardAE, ForwardBE  out  2  E operand mux select.
- StallF, StallD, FlushD, FlushE  out  1  pipeline control.
- MdBusy  out  1  MDU op in flight.
- MdDone  out  1  MDU writeback strobe, 1 cycle.
- MdRdW  out  REG_AW  MDU writeback destination, valid when MdDone=1.

Behaviour:
- Reset (async, rst_n=0): scoreboard all 0, counter 0, MdBusy=0, MdDone=0, MdRdW=0. The combinational outputs follow from the cleared state.
- Forwarding, per operand X in {1,2}:
  - Select 2'b10 if RsXE==RdM && RegWriteM && RsXE!=0.
  - Otherwise select 2'b01 if RsXE==RdW && RegWriteW && RsXE!=0.
  - Otherwise select 2'b00. M has priority over W.
- clr(r) = MdDone && MdRdW==r. A register being written back this cycle counts as not pending. The register file write-through makes the value visible to D in the same cycle.
- lwStall = ResultSrcE_MSB && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
- mdRawE = MdOpE && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
- sbStall: asserted if any of the following holds.
  - Rs1D!=0 && pend[Rs1D] && !clr(Rs1D).
  - The same condition for Rs2D.
  - (RegWriteD || MdOpD) && RdD!=0 && pend[RdD] && !clr(RdD) (WAW).
- structStall = MdOpD && (MdOpE || (MdBusy && !MdDone)).
- stall = lwStall | mdRawE | sbStall | structStall.
- If PCSrcE=1: FlushD=1, FlushE=1, StallF=StallD=0. Stalls raised by the wrong-path D instruction are suppressed.
- Otherwise: StallF=StallD=stall, FlushE=stall, FlushD=0.
- Issue: on a clk edge with MdOpE=1, load counter=MDU_LAT, latch RdE into MdRdW, and set pend[RdE] if RdE!=0.
  - MdOpE while MdBusy && !MdDone cannot occur by construction; flag it with an assertion.
- Counter: decrements each cycle while nonzero.
  - MdBusy = (counter!=0).
  - MdDone = (counter==1). The MDU result is written through the MDU's dedicated register-file port in that cycle, so writeback lands exactly MDU_LAT cycles after issue.
- Clear: when MdDone=1, pend[MdRdW] is cleared at the edge.
  - If an issue happens in the same cycle, apply the clear first, then the set. Back-to-back ops to the same Rd keep the bit set.
- In-flight MDU ops are older than any branch in E. PCSrcE never cancels the counter or scoreboard. Only reset does.
- At most one MDU op is in flight, so the scoreboard holds at most one set bit.

Decomposition:
- hazard_pkg: fwd_sel_e enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10). Also a REG_AW default constant.
- Sub-module md_scoreboard: pend vector, latency counter, MdRdW register, MdBusy and MdDone. The top level keeps the forwarding and stall/flush combinational logic.

Test Plan:
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 → ForwardAE=10. Same with Rs1E=0 → 00. Rs2E=7, RdW=7, RegWriteW=1 → ForwardBE=01.
- Load-use: ResultSrcE_MSB=1, RdE=3, Rs2D=3 → StallF=StallD=FlushE=1 for one cycle. Same with RdE=0 → no stall.
- MDU RAW (MDU_LAT=4): MdOpE=1, RdE=9 at cycle t, with Rs1D=9 held.
  - Required: stall at t (mdRawE) and at t+1..t+3 (scoreboard).
  - Required: MdDone=1 and MdRdW=9 at t+4, with no stall at t+4, and pend[9]=0 after t+4.
- Structural and WAW: MDU op issued at t with Rd=4, MdOpD=1 held from t.
  - Required: stall t..t+3, release at t+4 (MdDone), issue of the second op at t+5.
  - Required: RegWriteD=1, RdD=4, MdOpD=0 stalls t+1..t+3.
- Branch priority: sbStall condition active and PCSrcE=1 → FlushD=FlushE=1, StallF=StallD=0, with the counter and pend unaffected.
- Reset mid-op: rst_n=0 at t+2 after an issue → MdBusy, MdDone and pend clear immediately (async). No MdDone pulse after release.
